// File: rtl/game_pkg.sv
// game_pkg: grid geometry and cell indexing shared by the shot controller and
// the hit detector.
//   GRID_SIZE  - rows/columns per board
//   NUM_CELLS  - cells per board (bit count of fired_map)
//   CELL_IDX_W - width of a flat cell index row*GRID_SIZE+col
//   ROW_W      - width of a row or column coordinate
package game_pkg;

  localparam int GRID_SIZE  = 10;
  localparam int NUM_CELLS  = GRID_SIZE * GRID_SIZE;
  localparam int CELL_IDX_W = 7;
  localparam int ROW_W      = 4;

  localparam logic [ROW_W-1:0]      GRID_MAX  = ROW_W'(GRID_SIZE - 1);
  localparam logic [CELL_IDX_W-1:0] SHOTS_MAX = CELL_IDX_W'(NUM_CELLS);

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_FIRE,
    ACT_UP,
    ACT_DOWN,
    ACT_LEFT,
    ACT_RIGHT
  } action_t;

  function automatic logic [CELL_IDX_W-1:0] cell_index(input logic [ROW_W-1:0] row,
                                                       input logic [ROW_W-1:0] col);
    return CELL_IDX_W'(row) * CELL_IDX_W'(GRID_SIZE) + CELL_IDX_W'(col);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchroniser, counter-based debounce and rising
// edge detect for one raw push-button.
//   clk   - system clock
//   reset - asynchronous, active-low
//   raw   - raw asynchronous button level
//   level - debounced (stable) button level
//   press - one-cycle pulse when level goes 0->1
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             meta;
  logic             sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta  <= 1'b0;
      sync  <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      meta  <= raw;
      sync  <= meta;
      press <= 1'b0;
      if (sync == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // DEBOUNCE_CYCLES consecutive differing samples: accept the new level.
        // press is raised on the same edge so it marks the 0->1 of level.
        level <= sync;
        press <= sync;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_controller.sv
// shot_controller: turns five raw push-buttons into a registered cursor over
// the grid and a one-cycle shot pulse, remembering every fired cell.
//   clk          - system clock
//   reset        - asynchronous, active-low
//   btn_*        - raw asynchronous buttons (center = fire)
//   enable       - firing phase; presses ignored when low
//   clear        - synchronous new-game clear
//   cursor_row/col - registered cursor, 0..GRID_SIZE-1
//   shot         - one-cycle pulse, fire accepted at current cursor
//   repeat_shot  - one-cycle pulse, fire rejected (cell already fired)
//   shots_fired  - accepted shot count
//   fired_map    - bit row*GRID_SIZE+col set once that cell is fired
module shot_controller
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_up,
  input  logic                  btn_down,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_center,
  input  logic                  enable,
  input  logic                  clear,
  output logic [ROW_W-1:0]      cursor_row,
  output logic [ROW_W-1:0]      cursor_col,
  output logic                  shot,
  output logic                  repeat_shot,
  output logic [CELL_IDX_W-1:0] shots_fired,
  output logic [NUM_CELLS-1:0]  fired_map
);

  logic [4:0] raw_btns;
  logic [4:0] presses;
  logic [4:0] levels_unused;

  // bit order: 4 center, 3 up, 2 down, 1 left, 0 right
  assign raw_btns = {btn_center, btn_up, btn_down, btn_left, btn_right};

  for (genvar i = 0; i < 5; i++) begin : g_btn
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_btns[i]),
      .level(levels_unused[i]),
      .press(presses[i])
    );
  end

  action_t               action;
  logic [CELL_IDX_W-1:0] idx;

  assign idx = cell_index(cursor_row, cursor_col);

  // Fixed priority, losers dropped. Moves are also dropped while shot is high
  // so the hit detector sees the cursor of the fired cell.
  always_comb begin
    action = ACT_NONE;
    if (enable && !clear) begin
      if (presses[4])      action = ACT_FIRE;
      else if (!shot) begin
        if (presses[3])      action = ACT_UP;
        else if (presses[2]) action = ACT_DOWN;
        else if (presses[1]) action = ACT_LEFT;
        else if (presses[0]) action = ACT_RIGHT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cursor_row  <= '0;
      cursor_col  <= '0;
      shot        <= 1'b0;
      repeat_shot <= 1'b0;
      shots_fired <= '0;
      fired_map   <= '0;
    end else begin
      shot        <= 1'b0;
      repeat_shot <= 1'b0;
      if (clear) begin
        cursor_row  <= '0;
        cursor_col  <= '0;
        shots_fired <= '0;
        fired_map   <= '0;
      end else begin
        case (action)
          ACT_FIRE: begin
            if (!fired_map[idx]) begin
              shot           <= 1'b1;
              fired_map[idx] <= 1'b1;
              if (shots_fired < SHOTS_MAX) shots_fired <= shots_fired + 1'b1;
            end else begin
              repeat_shot <= 1'b1;
            end
          end
          ACT_UP:    cursor_row <= (cursor_row == GRID_MAX) ? '0 : cursor_row + 1'b1;
          ACT_DOWN:  cursor_row <= (cursor_row == '0) ? GRID_MAX : cursor_row - 1'b1;
          ACT_RIGHT: cursor_col <= (cursor_col == GRID_MAX) ? '0 : cursor_col + 1'b1;
          ACT_LEFT:  cursor_col <= (cursor_col == '0) ? GRID_MAX : cursor_col - 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_shot_controller.sv
module tb_shot_controller;

  localparam int N   = 4;
  localparam int GAP = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        btn_up = 0, btn_down = 0, btn_left = 0, btn_right = 0, btn_center = 0;
  logic        enable = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  cursor_row, cursor_col;
  logic        shot, repeat_shot;
  logic [6:0]  shots_fired;
  logic [99:0] fired_map;

  shot_controller #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_center(btn_center),
    .enable(enable), .clear(clear),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .shot(shot), .repeat_shot(repeat_shot),
    .shots_fired(shots_fired), .fired_map(fired_map)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: game state at the level of whole button presses
  int          m_row = 0, m_col = 0, m_cnt = 0;
  logic [99:0] m_map = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    btn_center = m[4]; btn_up = m[3]; btn_down = m[2]; btn_left = m[1]; btn_right = m[0];
  endtask

  task automatic model_reset();
    m_row = 0; m_col = 0; m_cnt = 0; m_map = '0;
  endtask

  // mask: [4] center, [3] up, [2] down, [1] left, [0] right
  task automatic model_apply(input logic [4:0] m, input logic en,
                             output int exp_shot, output int exp_rep);
    int idx;
    exp_shot = 0; exp_rep = 0;
    if (!en) return;
    if (m[4]) begin
      idx = m_row * 10 + m_col;
      if (m_map[idx]) exp_rep = 1;
      else begin
        exp_shot = 1; m_map[idx] = 1'b1;
        if (m_cnt < 100) m_cnt++;
      end
    end
    else if (m[3]) m_row = (m_row + 1) % 10;
    else if (m[2]) m_row = (m_row + 9) % 10;
    else if (m[1]) m_col = (m_col + 9) % 10;
    else if (m[0]) m_col = (m_col + 1) % 10;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".row"}, 128'(cursor_row), 128'(m_row));
    check({tag, ".col"}, 128'(cursor_col), 128'(m_col));
    check({tag, ".cnt"}, 128'(shots_fired), 128'(m_cnt));
    check({tag, ".map"}, 128'(fired_map), 128'(m_map));
  endtask

  // one clean press of the buttons in mask, held for hold cycles, then a gap
  task automatic press(input string tag, input logic [4:0] m, input int hold, input logic en);
    int shots, reps, es, er, pre_row, pre_col;
    logic [3:0] sr, sc;
    shots = 0; reps = 0; sr = '0; sc = '0;
    pre_row = m_row; pre_col = m_col;
    @(negedge clk);
    enable = en;
    drive(m);
    for (int i = 1; i <= hold + GAP; i++) begin
      @(negedge clk);
      if (shot) begin shots++; sr = cursor_row; sc = cursor_col; end
      if (repeat_shot) reps++;
      if (i == hold) drive(5'b0);
    end
    enable = 1'b1;
    model_apply(m, en, es, er);
    check({tag, ".shots"}, 128'(shots), 128'(es));
    check({tag, ".reps"}, 128'(reps), 128'(er));
    if (es == 1) begin
      check({tag, ".shot_row"}, 128'(sr), 128'(pre_row));
      check({tag, ".shot_col"}, 128'(sc), 128'(pre_col));
    end
    check_state(tag);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic move_to(input int r, input int c);
    while (m_row != r) press("nav_r", 5'b01000, 5, 1'b1);
    while (m_col != c) press("nav_c", 5'b00001, 5, 1'b1);
  endtask

  // edge number (1-based, counted from the next posedge) where cursor_row changes
  task automatic row_change_edge(input int limit, output int k, output int changes);
    logic [3:0] prev;
    prev = cursor_row; k = 0; changes = 0;
    for (int i = 1; i <= limit; i++) begin
      @(posedge clk); #1;
      if (cursor_row !== prev) begin
        changes++;
        if (k == 0) k = i;
        prev = cursor_row;
      end
    end
  endtask

  initial begin
    int k, ch, es, er;
    logic [4:0] m;

    // reset state
    #3;
    check_state("reset");
    check("reset.shot", 128'(shot), 128'(0));
    check("reset.rep", 128'(repeat_shot), 128'(0));
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // held button: one press, cursor moves on edge 2+N+1 after the raw rise
    btn_up = 1'b1;
    row_change_edge(20, k, ch);
    check("hold.edge", 128'(k), 128'(7));
    check("hold.changes", 128'(ch), 128'(1));
    @(negedge clk); btn_up = 1'b0;
    repeat (GAP) @(negedge clk);
    m_row = 1;
    check_state("hold");

    // bouncing button: 2-cycle pulses never accepted
    do_clear();
    for (int i = 0; i < 40; i++) begin
      btn_right = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    btn_right = 1'b0;
    repeat (GAP) @(negedge clk);
    check_state("bounce");

    // wrap-around in all four directions
    press("down_wrap", 5'b00100, 6, 1'b1);
    check("down_wrap.r9", 128'(cursor_row), 128'(9));
    press("left_wrap", 5'b00010, 6, 1'b1);
    check("left_wrap.c9", 128'(cursor_col), 128'(9));
    press("up_wrap", 5'b01000, 6, 1'b1);
    check("up_wrap.r0", 128'(cursor_row), 128'(0));
    press("right_wrap", 5'b00001, 6, 1'b1);
    check("right_wrap.c0", 128'(cursor_col), 128'(0));

    // fire at (7,3), then repeat
    move_to(7, 3);
    press("fire73", 5'b10000, 6, 1'b1);
    check("fire73.bit", 128'(fired_map[73]), 128'(1));
    press("repeat73", 5'b10000, 6, 1'b1);
    check("repeat73.cnt", 128'(shots_fired), 128'(1));

    // center and up together at (2,2): fire wins, up dropped
    do_clear();
    move_to(2, 2);
    press("center_up", 5'b11000, 7, 1'b1);
    check("center_up.bit22", 128'(fired_map[22]), 128'(1));

    // five shots, then clear, then a disabled fire
    for (int i = 0; i < 4; i++) begin
      move_to($urandom_range(9, 0), $urandom_range(9, 0));
      press("five", 5'b10000, 5, 1'b1);
    end
    do_clear();
    check_state("clear");
    press("disabled", 5'b10000, 6, 1'b0);

    // async reset in the middle of a press, button held through release
    press("pre_rst", 5'b10000, 5, 1'b1);
    @(negedge clk); btn_up = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk); #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_state("async_rst");
    @(negedge clk); reset = 1'b1;
    row_change_edge(12, k, ch);
    check("rst_hold.edge", 128'(k), 128'(7));
    @(negedge clk); btn_up = 1'b0;
    repeat (GAP) @(negedge clk);
    m_row = 1;
    check_state("rst_hold");

    // random presses, glitches and enable against the model
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(5, 0) == 0) begin
        m = 5'b1 << $urandom_range(4, 0);
        @(negedge clk); drive(m);
        repeat ($urandom_range(N - 1, 1)) @(negedge clk);
        drive(5'b0);
        repeat (GAP) @(negedge clk);
        model_apply(5'b0, 1'b1, es, er);
        check_state("glitch");
      end else begin
        if ($urandom_range(3, 0) == 0) m = 5'($urandom_range(31, 1));
        else if ($urandom_range(2, 0) == 0) m = 5'b10000;
        else m = 5'b1 << $urandom_range(3, 0);
        press("rand", m, $urandom_range(10, N + 1), $urandom_range(7, 0) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
